// File: rtl/pll_acq_pkg.sv
// Shared types for the PLL acquisition sequencer: state encoding and
// the registered output bundle decoded from a state.
package pll_acq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FREQ  = 3'd1,
    ST_PHASE = 3'd2,
    ST_TRACK = 3'd3,
    ST_FAIL  = 3'd4
  } acq_state_e;

  typedef struct packed {
    logic freq_acq;
    logic phase_acq;
    logic prnd_gen;
    logic prnd_dith;
    logic acq_done;
    logic acq_fail;
  } acq_out_t;

  // Loop enables and status flags that hold while resident in a state.
  function automatic acq_out_t outputs_for(acq_state_e st, logic dither);
    acq_out_t o;
    o = '0;
    case (st)
      ST_FREQ: begin
        o.freq_acq = 1'b1;
      end
      ST_PHASE: begin
        o.phase_acq = 1'b1;
        o.prnd_gen  = 1'b1;
      end
      ST_TRACK: begin
        o.phase_acq = 1'b1;
        o.prnd_gen  = 1'b1;
        o.prnd_dith = dither;
        o.acq_done  = 1'b1;
      end
      ST_FAIL: begin
        o.acq_fail = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pll_persist_counter.sv
// Counts consecutive cycles of a condition; clears when the condition drops
// or on request, saturates at all-ones. A threshold of 0 acts as 1.
module pll_persist_counter #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             cond_i,
  input  logic [WIDTH-1:0] threshold_i,
  output logic             hit_c
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] thr_m1;

  // hit_c fires on the cycle that completes the run, i.e. count_q+1 >= threshold
  always_comb begin
    thr_m1 = (threshold_i == '0) ? '0 : threshold_i - WIDTH'(1);
    hit_c  = cond_i && (count_q >= thr_m1);
  end

  always_comb begin
    count_d = count_q;
    if (clear_i || !cond_i) begin
      count_d = '0;
    end else if (count_q != '1) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pll_acq_sequencer.sv
// PLL acquisition sequencer: walks IDLE -> FREQ -> PHASE -> TRACK with
// lock persistence, per-phase timeout, relock counting and a sticky FAIL.
module pll_acq_sequencer
  import pll_acq_pkg::*;
#(
  parameter int unsigned NUM_SETTLE_BITS  = 6,
  parameter int unsigned NUM_TIMEOUT_BITS = 12,
  parameter int unsigned NUM_RELOCK_BITS  = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        locked,
  input  logic                        ditherRequest,
  input  logic [NUM_SETTLE_BITS-1:0]  settleCycles,
  input  logic [NUM_TIMEOUT_BITS-1:0] timeoutCycles,
  output logic                        freqAcqEnable,
  output logic                        phaseAcqEnable,
  output logic                        prndGeneratorEnable,
  output logic                        prndDitheringEnable,
  output logic                        acqDone,
  output logic                        acqFail,
  output logic [NUM_RELOCK_BITS-1:0]  relockCount,
  output logic [STATE_W-1:0]          state
);

  acq_state_e                  state_q;
  acq_state_e                  state_d;
  acq_out_t                    out_q;
  acq_out_t                    out_d;
  logic [NUM_TIMEOUT_BITS-1:0] tmo_q;
  logic [NUM_TIMEOUT_BITS-1:0] tmo_d;
  logic [NUM_RELOCK_BITS-1:0]  relock_q;
  logic [NUM_RELOCK_BITS-1:0]  relock_d;
  logic                        seen_low_q;
  logic                        seen_low_d;
  logic                        acquiring_c;
  logic                        settle_cond_c;
  logic                        settle_hit_c;
  logic                        tmo_hit_c;
  logic                        state_chg_c;

  // Settle condition: lock held while acquiring, lock lost while tracking
  always_comb begin
    acquiring_c   = (state_q == ST_FREQ) || (state_q == ST_PHASE);
    settle_cond_c = 1'b0;
    if (acquiring_c) begin
      settle_cond_c = locked;
    end else if (state_q == ST_TRACK) begin
      settle_cond_c = !locked;
    end
    tmo_hit_c = acquiring_c && (timeoutCycles != '0) &&
                (tmo_q >= timeoutCycles - NUM_TIMEOUT_BITS'(1));
  end

  pll_persist_counter #(
    .WIDTH (NUM_SETTLE_BITS)
  ) u_settle (
    .clk_i       (clock),
    .rst_i       (reset),
    .clear_i     (state_chg_c),
    .cond_i      (settle_cond_c),
    .threshold_i (settleCycles),
    .hit_c       (settle_hit_c)
  );

  // Next-state logic; abort overrides everything, settle beats timeout
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_FREQ;
        end
        ST_FREQ: begin
          if (settle_hit_c)   state_d = ST_PHASE;
          else if (tmo_hit_c) state_d = ST_FAIL;
        end
        ST_PHASE: begin
          if (settle_hit_c)   state_d = ST_TRACK;
          else if (tmo_hit_c) state_d = ST_FAIL;
        end
        ST_TRACK: begin
          if (settle_hit_c) state_d = ST_FREQ;
        end
        ST_FAIL: begin
          if (seen_low_q && start) state_d = ST_FREQ;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    state_chg_c = (state_d != state_q);
  end

  // Outputs decoded from the state being entered so they align with it
  always_comb begin
    out_d = outputs_for(state_d, ditherRequest);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Timeout, relock and FAIL re-arm bookkeeping
  always_comb begin
    tmo_d = tmo_q;
    if (state_chg_c) begin
      tmo_d = '0;
    end else if (acquiring_c && (tmo_q != '1)) begin
      tmo_d = tmo_q + NUM_TIMEOUT_BITS'(1);
    end

    relock_d = relock_q;
    if ((state_q == ST_TRACK) && (state_d == ST_FREQ) && (relock_q != '1)) begin
      relock_d = relock_q + NUM_RELOCK_BITS'(1);
    end

    seen_low_d = 1'b0;
    if ((state_q == ST_FAIL) && (state_d == ST_FAIL)) begin
      seen_low_d = seen_low_q || !start;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_q      <= '0;
      relock_q   <= '0;
      seen_low_q <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      relock_q   <= relock_d;
      seen_low_q <= seen_low_d;
    end
  end

  assign freqAcqEnable       = out_q.freq_acq;
  assign phaseAcqEnable      = out_q.phase_acq;
  assign prndGeneratorEnable = out_q.prnd_gen;
  assign prndDitheringEnable = out_q.prnd_dith;
  assign acqDone             = out_q.acq_done;
  assign acqFail             = out_q.acq_fail;
  assign relockCount         = relock_q;
  assign state               = state_q;

endmodule

// File: tb/tb_pll_acq_sequencer.sv
// Self-checking bench for pll_acq_sequencer: directed vector table, corner
// sequences, and randomized traffic against a behavioural model.
module tb_pll_acq_sequencer;

  localparam int unsigned SB = 6;
  localparam int unsigned TB = 12;
  localparam int unsigned RB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          locked;
  logic          ditherRequest;
  logic [SB-1:0] settleCycles;
  logic [TB-1:0] timeoutCycles;
  logic          freqAcqEnable;
  logic          phaseAcqEnable;
  logic          prndGeneratorEnable;
  logic          prndDitheringEnable;
  logic          acqDone;
  logic          acqFail;
  logic [RB-1:0] relockCount;
  logic [2:0]    state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model state
  int m_st, m_run, m_elapsed, m_rel;
  bit m_armed, m_dith;

  pll_acq_sequencer #(
    .NUM_SETTLE_BITS  (SB),
    .NUM_TIMEOUT_BITS (TB),
    .NUM_RELOCK_BITS  (RB)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .abort               (abort),
    .locked              (locked),
    .ditherRequest       (ditherRequest),
    .settleCycles        (settleCycles),
    .timeoutCycles       (timeoutCycles),
    .freqAcqEnable       (freqAcqEnable),
    .phaseAcqEnable      (phaseAcqEnable),
    .prndGeneratorEnable (prndGeneratorEnable),
    .prndDitheringEnable (prndDitheringEnable),
    .acqDone             (acqDone),
    .acqFail             (acqFail),
    .relockCount         (relockCount),
    .state               (state)
  );

  always #5 clock = ~clock;

  typedef struct {
    int start_at;
    int lock_at;
    int settle;
    int timeout;
    int n;
    int exp_st;
  } vec_t;

  // Expected output vector {state, freq, phase, gen, dith, done, fail, relocks}
  function automatic logic [12:0] expect_vec(int st, bit dith, int rel);
    logic f, p, g, d, dn, fl;
    f  = (st == 1);
    p  = (st == 2) || (st == 3);
    g  = p;
    d  = (st == 3) && dith;
    dn = (st == 3);
    fl = (st == 4);
    return {3'(st), f, p, g, d, dn, fl, 4'(rel)};
  endfunction

  function automatic logic [12:0] actual_vec();
    return {state, freqAcqEnable, phaseAcqEnable, prndGeneratorEnable,
            prndDitheringEnable, acqDone, acqFail, relockCount};
  endfunction

  task automatic check(string name, logic [12:0] exp);
    logic [12:0] act;
    act = actual_vec();
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got state=%0d en/flags=%b relocks=%0d, want state=%0d en/flags=%b relocks=%0d",
                  name, act[12:10], act[9:4], act[3:0], exp[12:10], exp[9:4], exp[3:0]);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_st = 0; m_run = 0; m_elapsed = 0; m_rel = 0; m_armed = 0; m_dith = 0;
  endtask

  task automatic do_reset(int settle, int timeout);
    reset = 1'b1;
    start = 1'b0; abort = 1'b0; locked = 1'b0; ditherRequest = 1'b0;
    settleCycles  = SB'(settle);
    timeoutCycles = TB'(timeout);
    model_reset();
    tick();
    reset = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using the inputs about to be sampled
  task automatic model_step();
    int  eff, nxt, run_new, el_new;
    bit  acq, cond, settled, timed;
    eff     = (settleCycles == 0) ? 1 : int'(settleCycles);
    acq     = (m_st == 1) || (m_st == 2);
    cond    = acq ? locked : ((m_st == 3) ? !locked : 1'b0);
    run_new = cond ? m_run + 1 : 0;
    settled = cond && (run_new >= eff);
    el_new  = acq ? m_elapsed + 1 : m_elapsed;
    timed   = acq && (timeoutCycles != 0) && (el_new >= int'(timeoutCycles));
    nxt = m_st;
    if (abort) nxt = 0;
    else if (m_st == 0 && start) nxt = 1;
    else if (acq && settled) nxt = m_st + 1;
    else if (acq && timed) nxt = 4;
    else if (m_st == 3 && settled) nxt = 1;
    else if (m_st == 4 && m_armed && start) nxt = 1;
    if (m_st == 3 && nxt == 1 && m_rel < 15) m_rel++;
    m_armed = (m_st == 4) && (nxt == 4) && (m_armed || !start);
    if (nxt != m_st) begin
      m_run = 0; m_elapsed = 0;
    end else begin
      m_run = run_new; m_elapsed = el_new;
    end
    m_dith = (nxt == 3) && ditherRequest;
    m_st   = nxt;
  endtask

  initial begin
    vec_t vecs[$];
    reset = 1'b0;
    start = 1'b0; abort = 1'b0; locked = 1'b0; ditherRequest = 1'b0;
    settleCycles = '0; timeoutCycles = '0;
    #1 reset = 1'b1;
    #2 check("reset_state", expect_vec(0, 0, 0));

    // {start_at, lock_at, settle, timeout, edges, expected state}
    vecs.push_back('{1, 1,    4, 100, 5,  2});
    vecs.push_back('{1, 1,    4, 100, 8,  2});
    vecs.push_back('{1, 1,    4, 100, 9,  3});
    vecs.push_back('{1, 1,    0, 0,   2,  2});
    vecs.push_back('{1, 1,    0, 0,   3,  3});
    vecs.push_back('{1, 1,    1, 0,   3,  3});
    vecs.push_back('{1, 1000, 4, 20,  20, 1});
    vecs.push_back('{1, 1000, 4, 20,  21, 4});
    vecs.push_back('{1, 1,    5, 5,   6,  2});
    vecs.push_back('{1, 1,    5, 5,   11, 3});
    vecs.push_back('{1, 1,    6, 5,   6,  4});
    vecs.push_back('{1, 3,    3, 0,   4,  1});
    vecs.push_back('{1, 3,    3, 0,   5,  2});
    vecs.push_back('{4, 1,    2, 0,   3,  0});
    vecs.push_back('{4, 1,    2, 0,   5,  1});
    vecs.push_back('{4, 1,    2, 0,   6,  2});

    foreach (vecs[i]) begin
      do_reset(vecs[i].settle, vecs[i].timeout);
      for (int k = 1; k <= vecs[i].n; k++) begin
        start  = (k >= vecs[i].start_at);
        locked = (k >= vecs[i].lock_at);
        tick();
      end
      check($sformatf("vec%0d", i), expect_vec(vecs[i].exp_st, 0, 0));
    end

    // Timeout into FAIL, then re-arm with start low then high
    do_reset(4, 20);
    start = 1'b1;
    repeat (21) tick();
    check("fail_entry", expect_vec(4, 0, 0));
    repeat (3) tick();
    check("fail_sticky_start_high", expect_vec(4, 0, 0));
    start = 1'b0; tick();
    check("fail_start_low", expect_vec(4, 0, 0));
    start = 1'b1; tick();
    check("fail_rearm_to_freq", expect_vec(1, 0, 0));

    // Full acquisition with lock arriving at cycle 10, dither, glitch and relock
    do_reset(4, 100);
    start = 1'b1;
    repeat (9) tick();
    locked = 1'b1;
    repeat (3) tick();
    check("acq_freq_hold", expect_vec(1, 0, 0));
    tick();
    check("acq_phase", expect_vec(2, 0, 0));
    repeat (3) tick();
    check("acq_phase_hold", expect_vec(2, 0, 0));
    tick();
    check("acq_track", expect_vec(3, 0, 0));
    ditherRequest = 1'b1; tick();
    check("track_dither_on", expect_vec(3, 1, 0));
    ditherRequest = 1'b0;
    locked = 1'b0; repeat (3) tick();
    locked = 1'b1; tick();
    check("track_glitch3", expect_vec(3, 0, 0));
    locked = 1'b0; repeat (3) tick();
    check("track_drop3", expect_vec(3, 0, 0));
    tick();
    check("track_relock", expect_vec(1, 0, 1));
    locked = 1'b1;

    // Abort on the same edge that would complete PHASE settling
    do_reset(4, 0);
    start = 1'b1; locked = 1'b1;
    repeat (8) tick();
    check("abort_pre_phase", expect_vec(2, 0, 0));
    abort = 1'b1; start = 1'b0; tick();
    check("abort_to_idle", expect_vec(0, 0, 0));
    abort = 1'b0;

    // Asynchronous reset in TRACK, no clock edge
    do_reset(2, 0);
    start = 1'b1; locked = 1'b1;
    repeat (5) tick();
    check("pre_async_reset_track", expect_vec(3, 0, 0));
    #2 reset = 1'b1;
    #1 check("async_reset_clears", expect_vec(0, 0, 0));
    tick();
    reset = 1'b0;

    // Relock counter saturation
    do_reset(1, 0);
    start = 1'b1; locked = 1'b1;
    repeat (3) tick();
    check("sat_track", expect_vec(3, 0, 0));
    for (int i = 1; i <= 20; i++) begin
      locked = 1'b0; tick();
      locked = 1'b1; tick(); tick();
      if (i == 10) check("relock_10", expect_vec(3, 0, 10));
    end
    check("relock_saturated", expect_vec(3, 0, 15));

    // Randomized traffic against the model
    for (int seg = 0; seg < 6; seg++) begin
      do_reset(int'($urandom_range(0, 5)),
               ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(3, 30)));
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 9) == 0) start = !start;
        abort = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 4) == 0) locked = !locked;
        if ($urandom_range(0, 7) == 0) ditherRequest = !ditherRequest;
        model_step();
        tick();
        check($sformatf("rand_s%0d_c%0d", seg, c), expect_vec(m_st, m_dith, m_rel));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pll_acq_sequencer.md
PLL_ACQ_SEQUENCER -- requirements
Module: pll_acq_sequencer

Interface
REQ-001 SHALL have parameter NUM_SETTLE_BITS, default 6, width of the settle counter and settleCycles.
REQ-002 SHALL have parameter NUM_TIMEOUT_BITS, default 12, width of the timeout counter and timeoutCycles.
REQ-003 SHALL have parameter NUM_RELOCK_BITS, default 4, width of relockCount.
REQ-004 SHALL have port clock, input, 1, the reference clock that also clocks the loop filter and lock detector.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, level request to begin acquisition.
REQ-007 SHALL have port abort, input, 1, forces a return to IDLE.
REQ-008 SHALL have port locked, input, 1, lock indication from the lock detector.
REQ-009 SHALL have port ditherRequest, input, 1, enables fractional dithering in TRACK.
REQ-010 SHALL have port settleCycles, input, NUM_SETTLE_BITS, consecutive locked cycles required to advance.
REQ-011 SHALL have port timeoutCycles, input, NUM_TIMEOUT_BITS, per-phase cycle budget; 0 disables the timeout.
REQ-012 SHALL have ports freqAcqEnable, phaseAcqEnable, prndGeneratorEnable and prndDitheringEnable, each output, 1, loop enables.
REQ-013 SHALL have ports acqDone and acqFail, each output, 1, status flags.
REQ-014 SHALL have port relockCount, output, NUM_RELOCK_BITS, saturating count of TRACK-to-FREQ relocks.
REQ-015 SHALL have port state, output, 3, current state encoding.

Function
REQ-016 SHALL implement the states IDLE=0, FREQ=1, PHASE=2, TRACK=3 and FAIL=4; all outputs SHALL be registered and change on the clock edge that enters a state.
REQ-017 In IDLE, all enables SHALL be 0 and the FSM SHALL move to FREQ when start=1.
REQ-018 In FREQ, freqAcqEnable=1 and all other enables=0; after settleCycles consecutive cycles with locked=1 the FSM SHALL move to PHASE.
REQ-019 In PHASE, phaseAcqEnable=1 and prndGeneratorEnable=1; after settleCycles consecutive cycles with locked=1 the FSM SHALL move to TRACK.
REQ-020 In TRACK, phaseAcqEnable=1, prndGeneratorEnable=1, prndDitheringEnable=ditherRequest registered, and acqDone=1.
REQ-021 In TRACK, settleCycles consecutive cycles with locked=0 SHALL move the FSM to FREQ and increment relockCount, saturating at all-ones.
REQ-022 The settle counter SHALL clear on any cycle where the condition is broken, on every state change, and SHALL saturate.
REQ-023 A settleCycles value of 0 SHALL behave as 1.
REQ-024 The timeout counter SHALL clear on entry to FREQ and PHASE.
REQ-025 In FREQ and PHASE, when timeoutCycles!=0 and the timeout counter reaches timeoutCycles, the FSM SHALL move to FAIL.
REQ-026 When settle completion and timeout occur in the same cycle, settle completion SHALL win.
REQ-027 In FAIL, all enables SHALL be 0 and acqFail=1; the FSM SHALL stay in FAIL until start=0 is followed by start=1, then move to FREQ with acqFail cleared.
REQ-028 abort=1 SHALL move the FSM to IDLE on the next edge from any state, with priority over every other transition, and SHALL clear acqDone and acqFail.
REQ-029 relockCount SHALL be cleared only by reset.
REQ-030 A locked glitch shorter than settleCycles SHALL cause no state change.

Reset
REQ-031 While reset=1, the block SHALL asynchronously set state=IDLE, all enables=0, acqDone=0, acqFail=0, relockCount=0, and both counters=0.
REQ-032 After reset deasserts, the first transition SHALL occur no earlier than the first clock edge at which start=1 is sampled.

Structure
REQ-033 The state encoding and its width SHALL be defined as constants in the shared package pll_acq_pkg.
REQ-034 A persistence counter that counts consecutive cycles of a condition, with clear and saturate, SHALL be a sub-module named pll_persist_counter.
REQ-035 The timeout counter SHALL remain inline in pll_acq_sequencer.

Verification
REQ-036 Test: settleCycles=4, timeoutCycles=100, start=1, locked=1 from cycle 10 -> FREQ, then PHASE after 4 locked cycles, then TRACK 4 cycles later with acqDone=1.
REQ-037 Test: timeoutCycles=20 with locked held at 0 -> FAIL 20 cycles after entering FREQ, acqFail=1, all enables 0; a start 0-then-1 sequence -> FREQ.
REQ-038 Test: in TRACK with settleCycles=4, a 3-cycle locked=0 glitch -> no change; a 4-cycle drop -> FREQ and relockCount=1.
REQ-039 Test: abort=1 while in PHASE at the same edge that settle completes -> IDLE, all enables 0.
REQ-040 Test: reset asserted mid-TRACK with no clock edge -> all outputs 0 immediately.
REQ-041 Test: 20 relocks with NUM_RELOCK_BITS=4 -> relockCount saturates at 15.
